// File: rtl/clk_util_pkg.sv
// Shared definitions for the clock-utility group: meter FSM states, default
// sizing constants and a counter-width helper.
`timescale 1ns/1ps
package clk_util_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_REPORT  = 2'd3
   } meter_state_t;

   localparam int DEF_WINDOW      = 100;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SYNC_STAGES = 2;

   // Bits needed to hold values 0..max_val.
   function automatic int ctr_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0; DEPTH >= 2.
`timescale 1ns/1ps
module sync_ff #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stage_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= {stage_reg[DEPTH-2:0], d};
      end
   end

   assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/clk_freq_meter.sv
// Counts mon_clk rising edges over WINDOW clk cycles and range-checks the count.
// Optional loss watchdog is compiled in with CLK_FREQ_METER_LOSS_DET_EN.
`timescale 1ns/1ps
module clk_freq_meter
   import clk_util_pkg::*;
#(
   parameter int WINDOW       = DEF_WINDOW,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int LOSS_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mon_clk,
   input  logic [CNT_W-1:0] exp_min,
   input  logic [CNT_W-1:0] exp_max,
   output logic [CNT_W-1:0] meas_cnt,
   output logic             meas_valid,
   output logic             freq_low,
   output logic             freq_high,
   output logic             clk_lost,
   output logic             busy
);

   localparam int PH_MAX = (WINDOW > SYNC_STAGES + 1) ? WINDOW : SYNC_STAGES + 1;
   localparam int PH_W   = ctr_width(PH_MAX);
   localparam logic [PH_W-1:0]  ARM_LAST = PH_W'(SYNC_STAGES);
   localparam logic [PH_W-1:0]  WIN_LAST = PH_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   if (WINDOW < 2 || SYNC_STAGES < 2 || LOSS_TIMEOUT < 1) begin : g_bad_params
      $error("clk_freq_meter: WINDOW and SYNC_STAGES must be >= 2, LOSS_TIMEOUT >= 1");
   end

   logic mon_sync;
   logic mon_prev_reg;
   logic mon_edge;

   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (mon_clk),
      .q   (mon_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         mon_prev_reg <= 1'b0;
      end else begin
         mon_prev_reg <= mon_sync;
      end
   end

   assign mon_edge = mon_sync & ~mon_prev_reg;

   meter_state_t     state_reg, state_next;
   logic [PH_W-1:0]  phase_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_inc;
   logic             report_now;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (en) state_next = ST_ARM;
         ST_ARM:     if (!en) state_next = ST_IDLE;
                     else if (phase_reg == ARM_LAST) state_next = ST_MEASURE;
         ST_MEASURE: if (!en) state_next = ST_IDLE;
                     else if (phase_reg == WIN_LAST) state_next = ST_REPORT;
         ST_REPORT:  state_next = en ? ST_MEASURE : ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Phase counts cycles spent in the current ARM or MEASURE visit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         phase_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next != state_reg || state_reg == ST_IDLE) begin
            phase_reg <= '0;
         end else begin
            phase_reg <= phase_reg + 1'b1;
         end
      end
   end

   // Saturating count; includes an edge seen in the last MEASURE cycle.
   assign cnt_inc    = (mon_edge && cnt_reg != CNT_MAX) ? cnt_reg + 1'b1 : cnt_reg;
   assign report_now = (state_reg == ST_MEASURE) && (state_next == ST_REPORT);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= (state_reg == ST_MEASURE) ? cnt_inc : '0;
      end
   end

   logic [CNT_W-1:0] meas_cnt_reg;
   logic             meas_valid_reg;
   logic             freq_low_reg;
   logic             freq_high_reg;
   logic             busy_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meas_cnt_reg   <= '0;
         meas_valid_reg <= 1'b0;
         freq_low_reg   <= 1'b0;
         freq_high_reg  <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         meas_valid_reg <= report_now;
         busy_reg       <= (state_next != ST_IDLE);
         if (report_now) begin
            meas_cnt_reg  <= cnt_inc;
            freq_low_reg  <= (cnt_inc < exp_min);
            freq_high_reg <= (cnt_inc > exp_max);
         end
      end
   end

`ifdef CLK_FREQ_METER_LOSS_DET_EN
   localparam int WD_W = ctr_width(LOSS_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LIMIT    = WD_W'(LOSS_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LIMIT_M1 = WD_W'(LOSS_TIMEOUT - 1);

   logic [WD_W-1:0] wd_reg;
   logic            clk_lost_reg;

   // Watchdog only runs while a measurement is in progress.
   always_ff @(posedge clk) begin
      if (rst || state_reg == ST_IDLE) begin
         wd_reg       <= '0;
         clk_lost_reg <= 1'b0;
      end else if (mon_edge) begin
         wd_reg       <= '0;
         clk_lost_reg <= 1'b0;
      end else begin
         if (wd_reg != WD_LIMIT) begin
            wd_reg <= wd_reg + 1'b1;
         end
         if (wd_reg >= WD_LIMIT_M1) begin
            clk_lost_reg <= 1'b1;
         end
      end
   end

   assign clk_lost = clk_lost_reg;
`else
   assign clk_lost = 1'b0;
`endif

   assign meas_cnt   = meas_cnt_reg;
   assign meas_valid = meas_valid_reg;
   assign freq_low   = freq_low_reg;
   assign freq_high  = freq_high_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: timestamps every mon_clk rise and predicts report
// cycles, counts and flags from them; a CNT_W=3 copy exercises saturation.
`timescale 1ns/1ps
module tb_clk_freq_meter;

   localparam int W   = 100;
   localparam int S   = 2;
   localparam int CW  = 16;
   localparam int CWS = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic           mon_clk = 1'b0;
   logic [CW-1:0]  exp_min = '0;
   logic [CW-1:0]  exp_max = '0;
   logic [CWS-1:0] exp_min_s = 3'd2;
   logic [CWS-1:0] exp_max_s = 3'd5;

   logic [CW-1:0]  meas_cnt;
   logic           meas_valid, freq_low, freq_high, clk_lost, busy;
   logic [CWS-1:0] meas_cnt_s;
   logic           meas_valid_s, freq_low_s, freq_high_s, clk_lost_s, busy_s;

   clk_freq_meter #(.WINDOW(W), .CNT_W(CW), .SYNC_STAGES(S), .LOSS_TIMEOUT(64)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mon_clk(mon_clk),
      .exp_min(exp_min), .exp_max(exp_max),
      .meas_cnt(meas_cnt), .meas_valid(meas_valid), .freq_low(freq_low),
      .freq_high(freq_high), .clk_lost(clk_lost), .busy(busy)
   );

   clk_freq_meter #(.WINDOW(W), .CNT_W(CWS), .SYNC_STAGES(S), .LOSS_TIMEOUT(64)) u_dut_sat (
      .clk(clk), .rst(rst), .en(en), .mon_clk(mon_clk),
      .exp_min(exp_min_s), .exp_max(exp_max_s),
      .meas_cnt(meas_cnt_s), .meas_valid(meas_valid_s), .freq_low(freq_low_s),
      .freq_high(freq_high_s), .clk_lost(clk_lost_s), .busy(busy_s)
   );

   always #0.5 clk = ~clk;

   // mon_clk edges stay on .25/.75 ns, clear of clk edges at .0/.5 ns.
   realtime mon_half = 5.0;
   bit      mon_run  = 1'b1;
   initial begin
      #0.25;
      forever begin
         #(mon_half);
         if (mon_run) mon_clk = ~mon_clk;
         else         mon_clk = 1'b0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // A rise first sampled at posedge p0 is counted at posedge p0+S.
   int edge_at[$];
   always @(posedge mon_clk) edge_at.push_back(cyc + 1 + S);

   int total = 0;
   int bad   = 0;
   int run_start = -1;
   int run_stop  = -1;
   int m_cnt = 0, s_cnt = 0;
   bit m_low = 0, m_high = 0, s_low = 0, s_high = 0;
   int n_reports = 0;

   function automatic int model_count(input int k);
      int n = 0;
      foreach (edge_at[i]) begin
         if (edge_at[i] >= k - W + 1 && edge_at[i] <= k) n++;
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
         $error("check %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic set_en(input logic v);
      en = v;
      if (v) begin
         run_start = cyc + 1;
         run_stop  = -1;
      end else begin
         run_stop = cyc + 1;
      end
   endtask

   task automatic step();
      bit exp_valid;
      bit exp_busy;
      int first_k;
      @(negedge clk);
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      if (rst) begin
         run_start = -1;
         run_stop  = -1;
         m_cnt = 0; m_low = 0; m_high = 0;
         s_cnt = 0; s_low = 0; s_high = 0;
      end else begin
         exp_busy = (run_start >= 0) && (cyc >= run_start) && (run_stop < 0 || cyc < run_stop);
         first_k  = run_start + S + 1 + W;
         exp_valid = exp_busy && (cyc >= first_k) && (((cyc - first_k) % (W + 1)) == 0);
         if (exp_valid) begin
            m_cnt  = model_count(cyc);
            m_low  = (m_cnt < int'(exp_min));
            m_high = (m_cnt > int'(exp_max));
            s_cnt  = (m_cnt > 7) ? 7 : m_cnt;
            s_low  = (s_cnt < int'(exp_min_s));
            s_high = (s_cnt > int'(exp_max_s));
            n_reports++;
            $display("report %0d cyc=%0d cnt=%0d (exp %0d..%0d) low=%0b high=%0b sat_cnt=%0d",
                     n_reports, cyc, meas_cnt, exp_min, exp_max, freq_low, freq_high, meas_cnt_s);
         end
      end
      check("meas_valid", meas_valid, exp_valid);
      check("busy", busy, exp_busy);
      check("meas_cnt", meas_cnt, m_cnt);
      check("freq_low", freq_low, m_low);
      check("freq_high", freq_high, m_high);
      check("sat_meas_cnt", meas_cnt_s, s_cnt);
      check("sat_freq_low", freq_low_s, s_low);
      check("sat_freq_high", freq_high_s, s_high);
`ifndef CLK_FREQ_METER_LOSS_DET_EN
      check("clk_lost", clk_lost, 1'b0);
`endif
   endtask

   initial begin
      int nominal;
      int lo;

      // Reset values
      repeat (3) step();
      rst = 1'b0;
      step();

      // 100 MHz, in range
      exp_min = 16'd9; exp_max = 16'd11;
      mon_half = 5.0;
      set_en(1'b1);
      repeat (3 * (W + 1) + S + 10) step();

      // 200 MHz mid-run, same range
      mon_half = 2.5;
      repeat (2 * (W + 1) + 50) step();

      // 100 MHz against a higher range
      mon_half = 5.0;
      exp_min = 16'd15; exp_max = 16'd25;
      repeat (2 * (W + 1) + 7) step();

      // Randomized frequencies and ranges, including exp_min > exp_max
      for (int p = 0; p < 5; p++) begin
         mon_half = 0.5 * $urandom_range(4, 30);
         nominal  = int'(W / (2.0 * mon_half));
         lo       = nominal + int'($urandom_range(0, 6)) - 3;
         exp_min  = CW'((lo < 0) ? 0 : lo);
         exp_max  = CW'(nominal + int'($urandom_range(0, 6)) - 2);
         exp_min_s = CWS'($urandom_range(0, 7));
         exp_max_s = CWS'($urandom_range(0, 7));
         repeat (2 * (W + 1) + $urandom_range(0, 60)) step();
      end

      // en dropped in MEASURE cycle 50: window abandoned, outputs hold
      mon_half = 5.0;
      exp_min = 16'd9; exp_max = 16'd11;
      set_en(1'b0);
      repeat (5) step();
      set_en(1'b1);
      while (cyc < run_start + S + 50) step();
      set_en(1'b0);
      repeat (W + 20) step();

      // Reset mid-window
      set_en(1'b1);
      repeat (60) step();
      rst = 1'b1;
      en  = 1'b0;
      step();
      rst = 1'b0;
      repeat (5) step();

`ifdef CLK_FREQ_METER_LOSS_DET_EN
      // Stopped monitored clock, then restart
      set_en(1'b1);
      repeat (20) step();
      mon_run = 1'b0;
      repeat (80) step();
      check("clk_lost_set", clk_lost, 1'b1);
      mon_run = 1'b1;
      repeat (15) step();
      check("clk_lost_clear", clk_lost, 1'b0);
      set_en(1'b0);
      repeat (3) step();
      check("clk_lost_idle", clk_lost, 1'b0);
`endif

      set_en(1'b0);
      repeat (5) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Measures the frequency of an asynchronous monitored clock, such as the output of the clock mux, against the block's own reference clock. It counts monitored rising edges over a fixed window of reference cycles and reports the count. It also compares the count against a programmable expected range, which lets the design and benches confirm that a clock-select change took effect. It sits downstream of the clock mux in the clock-utility group.

## Interface
Parameters:
- WINDOW, 100: measurement window length, in `clk` cycles (≥ 2).
- CNT_W, 16: width of the edge counter and the compare values.
- SYNC_STAGES, 2: synchronizer depth for `mon_clk` (≥ 2).
- LOSS_TIMEOUT, 64: `clk` cycles without a monitored edge before loss is flagged. Used only when the loss feature is compiled in.

Ports:
- clk  in  1  reference clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level enable; measurement runs continuously while it is high.
- mon_clk  in  1  monitored clock, asynchronous to `clk`.
- exp_min  in  CNT_W  lowest acceptable edge count, sampled in REPORT.
- exp_max  in  CNT_W  highest acceptable edge count, sampled in REPORT.
- meas_cnt  out  CNT_W  edge count from the last completed window.
- meas_valid  out  1  one-cycle pulse when `meas_cnt` and the flags update.
- freq_low  out  1  last count < `exp_min`.
- freq_high  out  1  last count > `exp_max`.
- clk_lost  out  1  monitored clock has stopped (only with the loss feature).
- busy  out  1  high in ARM, MEASURE and REPORT.

## Operation
- `mon_clk` passes through an SYNC_STAGES-flop synchronizer, then a `prev` flop.
- edge = sync & ~prev.
- Valid only if f(mon_clk) < f(clk)/2; above that, counts alias.
- FSM states: IDLE, ARM, MEASURE, REPORT.
  - IDLE → ARM when `en`=1.
  - ARM lasts SYNC_STAGES+1 cycles, flushing the synchronizer. The edge counter is held at 0 and edges are ignored.
  - ARM → MEASURE. MEASURE lasts exactly WINDOW cycles, adding 1 to the counter for each detected edge.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
  - MEASURE → REPORT, which lasts one cycle and produces:
    - `meas_cnt` = counter;
    - `freq_low` = (cnt < exp_min);
    - `freq_high` = (cnt > exp_max);
    - `meas_valid` = 1.
  - REPORT → MEASURE if `en`=1. The counter clears and the next window starts immediately; the synchronizer is already primed, so ARM is not repeated.
  - REPORT → IDLE if `en`=0.
- `en` falling in ARM or MEASURE moves to IDLE on the next cycle. The window is abandoned: no `meas_valid`, outputs hold their previous values.
- An edge detected in the final MEASURE cycle is counted. An edge in the REPORT cycle belongs to no window.
- Unsigned compares. If `exp_min` > `exp_max`, every count sets at least one flag; this is not an error.
- `meas_cnt`, `freq_low` and `freq_high` hold between reports.

## Timing
- Reset values: FSM = IDLE; `meas_cnt`=0, `meas_valid`=0, `freq_low`=0, `freq_high`=0, `clk_lost`=0, `busy`=0. Synchronizer and counters clear.
- `rst` mid-window: the window is lost and all outputs return to their reset values on the next edge.
- `en` sampled high at cycle t: `busy`=1 at t+1, and the first `meas_valid` appears at t+1+(SYNC_STAGES+1)+WINDOW.
- In continuous mode, `meas_valid` repeats every WINDOW+1 cycles.
- Edge-to-count latency is SYNC_STAGES+1 cycles. Expected count accuracy is ±1 edge from window phase.
- All outputs are registered.

## Configuration
- `CLK_FREQ_METER_LOSS_DET_EN` defined: a watchdog counts `clk` cycles since the last detected edge, while `busy`=1.
  - At LOSS_TIMEOUT, `clk_lost` is set.
  - `clk_lost` clears on the next detected edge.
  - The watchdog resets in IDLE.
- Not defined: there is no watchdog logic and `clk_lost` is tied to 0.

## Structure
- Shared package `clk_util_pkg`: FSM state enum (IDLE/ARM/MEASURE/REPORT), default WINDOW/CNT_W constants.
- Sub-module `sync_ff` (parameterized depth, single-bit, reset to 0). It is reusable by other clock utilities.

## Test plan
- `clk` period 1 ns, WINDOW=100, `mon_clk` 100 MHz (10 ns), `en`=1, exp 9..11 → `meas_valid` pulses every 101 cycles, `meas_cnt` ∈ {9,10,11}, both flags 0.
- `mon_clk` switched to 200 MHz mid-run with exp 9..11 → the first full following window gives `meas_cnt` ∈ {19,20,21} and `freq_high`=1.
- `mon_clk` 100 MHz with exp 15..25 → `freq_low`=1, `freq_high`=0.
- `en` dropped at MEASURE cycle 50 → no `meas_valid`, `busy`=0 next cycle, `meas_cnt` unchanged. `rst` mid-window → all outputs 0.
- CNT_W=3 at 100 MHz → `meas_cnt`=7 (saturated, no wrap).
- With `CLK_FREQ_METER_LOSS_DET_EN`: `mon_clk` held at 0 → `clk_lost`=1 within 64 cycles; restart the clock → `clk_lost`=0 after the first synchronized edge.
